// File: rtl/vga_frame_checker.sv
// VGA stream monitor: checks hsync/vsync geometry, counts frames and signs each
// frame's active pixels with CRC-16-CCITT.
module vga_frame_checker #(
    parameter int unsigned IRW         = 4,
    parameter int unsigned IGW         = 4,
    parameter int unsigned IBW         = 4,
    parameter bit          HS_POL      = 1'b0,
    parameter bit          VS_POL      = 1'b0,
    parameter int unsigned H_TOTAL     = 800,
    parameter int unsigned H_SYNC      = 96,
    parameter int unsigned H_ACT_START = 144,
    parameter int unsigned H_ACT       = 640,
    parameter int unsigned V_TOTAL     = 525,
    parameter int unsigned V_SYNC      = 2,
    parameter int unsigned V_ACT_START = 35,
    parameter int unsigned V_ACT       = 480
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clk_en,
    input  logic            start,
    input  logic            hs,
    input  logic            vs,
    input  logic [IRW-1:0]  r_in,
    input  logic [IGW-1:0]  g_in,
    input  logic [IBW-1:0]  b_in,
    output logic [6:0]      f_cnt,
    output logic            f_start,
    output logic [11:0]     h_cnt,
    output logic [11:0]     v_cnt,
    output logic [15:0]     crc,
    output logic            crc_vld,
    output logic            err_h,
    output logic            err_v,
    output logic            locked
);

    localparam int unsigned PW = IRW + IGW + IBW;
    localparam logic [11:0] CntMax = 12'hFFF;
    localparam logic [12:0] HLo = 13'(H_ACT_START);
    localparam logic [12:0] HHi = 13'(H_ACT_START + H_ACT);
    localparam logic [12:0] VLo = 13'(V_ACT_START);
    localparam logic [12:0] VHi = 13'(V_ACT_START + V_ACT);

    typedef enum logic [1:0] {StIdle, StSeek, StRun} state_e;

    state_e        state_q, state_d;
    logic          hs_q, vs_q;
    logic [PW-1:0] pix_q;
    logic [11:0]   h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d, vs_w_q, vs_w_d;
    logic [15:0]   crc_run_q, crc_run_d, crc_q, crc_d;
    logic [6:0]    f_cnt_q, f_cnt_d;
    logic          h_seen_q, h_seen_d, frame_err_q, frame_err_d;
    logic          err_h_q, err_h_d, err_v_q, err_v_d, locked_q, locked_d;
    logic          f_start_q, f_start_d, crc_vld_q, crc_vld_d;

    logic hs_a, vs_a, hs_rise, hs_fall, vs_rise, vs_fall, pix_act, h_err, v_err;
    logic [12:0] h_pos1, v_pos1;

    // MSB-first CRC-16-CCITT over one full pixel word.
    function automatic logic [15:0] crc_step(input logic [15:0] c, input logic [PW-1:0] d);
        logic [15:0] x;
        logic        fb;
        x = c;
        for (int i = PW - 1; i >= 0; i--) begin
            fb = x[15] ^ d[i];
            x  = {x[14:0], 1'b0};
            if (fb) x = x ^ 16'h1021;
        end
        return x;
    endfunction

    assign hs_a    = (hs == HS_POL);
    assign vs_a    = (vs == VS_POL);
    assign hs_rise = hs_a & ~hs_q;
    assign hs_fall = ~hs_a & hs_q;
    assign vs_rise = vs_a & ~vs_q;
    assign vs_fall = ~vs_a & vs_q;
    assign h_pos1  = 13'(h_cnt_q) + 13'd1;
    assign v_pos1  = 13'(v_cnt_q) + 13'd1;

    // pix_q holds the pixel whose position is h_cnt/v_cnt, so the window lines up.
    assign pix_act = ({1'b0, h_cnt_q} >= HLo) && ({1'b0, h_cnt_q} < HHi) &&
                     ({1'b0, v_cnt_q} >= VLo) && ({1'b0, v_cnt_q} < VHi);

    always_comb begin
        state_d     = state_q;
        h_cnt_d     = h_cnt_q;
        v_cnt_d     = v_cnt_q;
        vs_w_d      = vs_w_q;
        crc_run_d   = crc_run_q;
        crc_d       = crc_q;
        f_cnt_d     = f_cnt_q;
        h_seen_d    = h_seen_q;
        frame_err_d = frame_err_q;
        err_h_d     = err_h_q;
        err_v_d     = err_v_q;
        locked_d    = locked_q;
        f_start_d   = 1'b0;
        crc_vld_d   = 1'b0;
        h_err       = 1'b0;
        v_err       = 1'b0;

        if (hs_rise) h_cnt_d = '0;
        else if (h_cnt_q != CntMax) h_cnt_d = h_cnt_q + 12'd1;

        if (vs_rise) v_cnt_d = '0;
        else if (hs_rise && v_cnt_q != CntMax) v_cnt_d = v_cnt_q + 12'd1;

        if (vs_rise) vs_w_d = hs_rise ? 12'd1 : 12'd0;
        else if (vs_a && hs_rise && vs_w_q != CntMax) vs_w_d = vs_w_q + 12'd1;

        if (vs_rise) crc_run_d = 16'hFFFF;
        else if (pix_act) crc_run_d = crc_step(crc_run_q, pix_q);

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d  = StSeek;
                    err_h_d  = 1'b0;
                    err_v_d  = 1'b0;
                    locked_d = 1'b0;
                    f_cnt_d  = '0;
                end
            end
            StSeek: begin
                if (start) begin
                    err_h_d  = 1'b0;
                    err_v_d  = 1'b0;
                    locked_d = 1'b0;
                    f_cnt_d  = '0;
                end else if (vs_rise) begin
                    state_d     = StRun;
                    h_cnt_d     = '0;
                    v_cnt_d     = '0;
                    crc_run_d   = 16'hFFFF;
                    h_seen_d    = 1'b0;
                    frame_err_d = 1'b0;
                end
            end
            StRun: begin
                if (start) begin
                    state_d  = StSeek;
                    err_h_d  = 1'b0;
                    err_v_d  = 1'b0;
                    locked_d = 1'b0;
                    f_cnt_d  = '0;
                end else begin
                    // Lines are only judged once a complete line start has been seen.
                    if (h_seen_q && hs_rise && h_pos1 != 13'(H_TOTAL)) h_err = 1'b1;
                    if (h_seen_q && hs_fall && h_pos1 != 13'(H_SYNC)) h_err = 1'b1;
                    if (hs_rise) h_seen_d = 1'b1;
                    if (vs_fall && vs_w_q != 12'(V_SYNC)) v_err = 1'b1;
                    if (vs_rise && v_pos1 != 13'(V_TOTAL)) v_err = 1'b1;
                    err_h_d = err_h_q | h_err;
                    err_v_d = err_v_q | v_err;
                    if (vs_rise) begin
                        f_start_d   = 1'b1;
                        crc_vld_d   = 1'b1;
                        f_cnt_d     = f_cnt_q + 7'd1;
                        crc_d       = crc_run_q;
                        locked_d    = ~(frame_err_q | h_err | v_err);
                        frame_err_d = 1'b0;
                    end else if (h_err || v_err) begin
                        locked_d    = 1'b0;
                        frame_err_d = 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            hs_q        <= 1'b0;
            vs_q        <= 1'b0;
            pix_q       <= '0;
            h_cnt_q     <= '0;
            v_cnt_q     <= '0;
            vs_w_q      <= '0;
            crc_run_q   <= 16'hFFFF;
            crc_q       <= 16'hFFFF;
            f_cnt_q     <= '0;
            h_seen_q    <= 1'b0;
            frame_err_q <= 1'b0;
            err_h_q     <= 1'b0;
            err_v_q     <= 1'b0;
            locked_q    <= 1'b0;
            f_start_q   <= 1'b0;
            crc_vld_q   <= 1'b0;
        end else begin
            // Strobes drop on the next clock even when the pixel enable is low.
            f_start_q <= clk_en & f_start_d;
            crc_vld_q <= clk_en & crc_vld_d;
            if (clk_en) begin
                state_q     <= state_d;
                hs_q        <= hs_a;
                vs_q        <= vs_a;
                pix_q       <= {r_in, g_in, b_in};
                h_cnt_q     <= h_cnt_d;
                v_cnt_q     <= v_cnt_d;
                vs_w_q      <= vs_w_d;
                crc_run_q   <= crc_run_d;
                crc_q       <= crc_d;
                f_cnt_q     <= f_cnt_d;
                h_seen_q    <= h_seen_d;
                frame_err_q <= frame_err_d;
                err_h_q     <= err_h_d;
                err_v_q     <= err_v_d;
                locked_q    <= locked_d;
            end
        end
    end

    assign f_cnt   = f_cnt_q;
    assign f_start = f_start_q;
    assign h_cnt   = h_cnt_q;
    assign v_cnt   = v_cnt_q;
    assign crc     = crc_q;
    assign crc_vld = crc_vld_q;
    assign err_h   = err_h_q;
    assign err_v   = err_v_q;
    assign locked  = locked_q;

endmodule
